bp_table_ctrl: RTL and testbench
================================

BP_TABLE_CTRL -- requirements
Module: bp_table_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of 2-bit predictor counters.
REQ-002 SHALL have parameter IDX_W, default 4, index width, equal to log2(ENTRIES).
REQ-003 SHALL have parameter DEPTH, default 4, maximum number of outstanding predictions (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  prediction request.
REQ-007 SHALL have port req_idx  input  IDX_W  counter index of the requesting branch.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle; combinational, equal to pending<DEPTH.
REQ-009 SHALL have port pred_valid  output  1  one-cycle prediction strobe.
REQ-010 SHALL have port pred_taken  output  1  predicted direction.
REQ-011 SHALL have port res_valid  input  1  resolution of the oldest outstanding branch.
REQ-012 SHALL have port res_taken  input  1  actual direction of that branch.
REQ-013 SHALL have port flush  input  1  discard all outstanding predictions.
REQ-014 SHALL have port mispredict  output  1  one-cycle strobe: resolved direction differed from prediction.
REQ-015 SHALL have port pending  output  log2(DEPTH)+1  count of outstanding predictions.

Function
REQ-016 SHALL hold ENTRIES 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 SHALL accept a request on an edge where req_valid and req_ready are both 1; pred_valid=1 in the next cycle only, with pred_taken = bit 1 of table[req_idx] as sampled at the accepting edge.
REQ-018 SHALL push {req_idx, pred_taken} into an in-order pending FIFO on each accepted request.
REQ-019 SHALL, on res_valid with pending>0, pop the oldest entry and update its counter: taken increments, saturating at 11; not-taken decrements, saturating at 00.
REQ-020 SHALL assert mispredict for exactly one cycle after a pop whose stored prediction differs from res_taken.
REQ-021 SHALL ignore res_valid when pending==0: no counter change, no mispredict.
REQ-022 SHALL, when a request and a resolution coincide on the same index, predict from the pre-update counter value.
REQ-023 SHALL, when a push and a pop coincide, leave pending unchanged and wrap the FIFO pointers modulo DEPTH.
REQ-024 SHALL keep req_ready=0 when pending==DEPTH, even if res_valid=1 in the same cycle (no fall-through).
REQ-025 SHALL, on flush, clear pending to 0 and leave counters intact; flush overrides a same-cycle request (no pred_valid) and a same-cycle resolution (no update, no mispredict).

Reset
REQ-026 SHALL, while rst=1, set all counters to 00, pending to 0, FIFO pointers to 0, and pred_valid, pred_taken and mispredict to 0.
REQ-027 SHALL discard any in-flight prediction or mispredict strobe when rst asserts mid-operation.

Structure
REQ-028 SHALL take the counter-state constants (SNT, WNT, WT, ST), CTR_W=2 and the default IDX_W from shared package bp_pkg.
REQ-029 SHALL implement the pending FIFO as sub-module bp_pend_fifo (DEPTH entries of IDX_W+1 bits, count output).

Verification
REQ-030 SHALL cover: after reset, request idx 3 -> pred_taken=0; resolve taken x2 -> counter 10; next request idx 3 -> pred_taken=1.
REQ-031 SHALL cover: 4 requests without resolution -> pending=4, req_ready=0; 5th request held until one res_valid pops the oldest entry.
REQ-032 SHALL cover: predict NT for idx 5, resolve taken -> mispredict pulses for exactly 1 cycle; resolve NT on the next branch -> no pulse.
REQ-033 SHALL cover: counter at 11 resolved taken 3x -> stays 11; counter at 00 resolved NT -> stays 00.
REQ-034 SHALL cover: flush with 3 pending plus same-cycle req and res -> pending=0, no pred_valid, no mispredict, counters unchanged.
REQ-035 SHALL cover: rst asserted between request and pred_valid -> pred_valid stays 0, all counters return to 00.

Source files
------------

// File: rtl/bp_pkg.sv
// Purpose: shared constants, types and counter-update helper for the branch predictor table.
// Latency: n/a (package).
// Backpressure: n/a (package).
package bp_pkg;

    // Width of one saturating predictor counter
    localparam int CTR_W    = 2;

    // Default index width (16 counters)
    localparam int BP_IDX_W = 4;

    typedef logic [CTR_W-1:0] ctr_t;

    // Counter states; bit 1 is the predicted direction
    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Next counter value after a resolution, saturating at both ends
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = ctr_t'(cur + 1'b1);
            end
        end else begin
            if (cur != SNT) begin
                nxt = ctr_t'(cur - 1'b1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_pend_fifo.sv
// Purpose: in-order FIFO of outstanding predictions ({idx, predicted direction}) with occupancy count.
// Latency: pop data is combinational from the head; push/pop/clear take effect at the next clock edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module bp_pend_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = BP_IDX_W + 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     pop_dat,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Head entry is always visible; only meaningful while count is non-zero
    assign pop_dat = mem[rd_ptr];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset is needed
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/bp_table_ctrl.sv
// Purpose: table of 2-bit saturating branch predictors with in-order resolution tracking.
// Latency: prediction one cycle after an accepted request; mispredict one cycle after a resolution.
// Backpressure: req_ready drops while DEPTH predictions are outstanding; a same-cycle resolution does not reopen it.
module bp_table_ctrl
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = BP_IDX_W,
    parameter int DEPTH   = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_idx,
    output logic             req_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic             flush,
    output logic             mispredict,
    output logic [CNT_W-1:0] pending
);

    ctr_t             ctr_q [ENTRIES];

    logic             accept;
    logic             pop;
    logic             req_pred;
    logic [IDX_W:0]   pop_dat;
    logic [IDX_W-1:0] pop_idx;
    logic             pop_pred;

    // Readiness looks only at the current count, so a full FIFO never falls through
    assign req_ready = (pending < CNT_W'(DEPTH));

    // Flush wins over both a new request and a resolution in the same cycle
    assign accept    = req_valid && req_ready && !flush;
    assign pop       = res_valid && (pending != '0) && !flush;

    // Prediction reads the counter before any same-cycle update lands
    assign req_pred  = ctr_q[req_idx][CTR_W-1];

    assign pop_idx   = pop_dat[IDX_W:1];
    assign pop_pred  = pop_dat[0];

    bp_pend_fifo #(
        .DEPTH (DEPTH),
        .W     (IDX_W + 1)
    ) u_pend_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (accept),
        .push_dat ({req_idx, req_pred}),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .count    (pending)
    );

    // Train the counter of the oldest outstanding branch on each resolution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= SNT;
            end
        end else if (pop) begin
            ctr_q[pop_idx] <= ctr_next(ctr_q[pop_idx], res_taken);
        end
    end

    // Registered prediction and mispredict strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            pred_valid <= accept;
            if (accept) begin
                pred_taken <= req_pred;
            end
            mispredict <= pop && (pop_pred != res_taken);
        end
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Purpose: directed self-checking bench for bp_table_ctrl with a reference model and scoreboard queues.
// Latency: checks outputs 1 time unit after each rising clock edge.
// Backpressure: mirrors req_ready/pending in the model and checks them every cycle.
module tb_bp_table_ctrl;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int DEPTH   = 4;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_idx   = 4'd0;
    logic       req_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic       res_valid = 1'b0;
    logic       res_taken = 1'b0;
    logic       flush     = 1'b0;
    logic       mispredict;
    logic [2:0] pending;

    int errors = 0;
    int checks = 0;

    // Scoreboard queues and reference model state
    bit         exp_pred [$];
    bit         exp_mp   [$];
    logic [4:0] m_fifo   [$];
    logic [1:0] m_tab    [ENTRIES];
    int         m_pend;

    logic last_pv;
    logic last_pt;
    logic last_mp;

    bp_table_ctrl #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .flush      (flush),
        .mispredict (mispredict),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pred.delete();
        exp_mp.delete();
        m_fifo.delete();
        for (int i = 0; i < ENTRIES; i++) begin
            m_tab[i] = 2'b00;
        end
        m_pend = 0;
    endtask

    // One clock cycle with the inputs currently driven: predict, advance, compare
    task automatic cyc();
        logic       acc;
        logic       pp;
        logic       pr;
        logic [4:0] e;
        logic [3:0] pi;
        bit         ept;
        bit         emp;
        chk("req_ready", 32'(req_ready), 32'(m_pend < DEPTH));
        chk("pending", 32'(pending), 32'(m_pend));
        acc = req_valid && (m_pend < DEPTH) && !flush;
        pp  = res_valid && (m_pend > 0) && !flush;
        pr  = m_tab[req_idx][1];
        if (flush) begin
            m_fifo.delete();
        end
        if (pp) begin
            e  = m_fifo.pop_front();
            pi = e[4:1];
            exp_mp.push_back(e[0] != res_taken);
            if (res_taken) begin
                if (m_tab[pi] != 2'b11) m_tab[pi] = m_tab[pi] + 2'd1;
            end else begin
                if (m_tab[pi] != 2'b00) m_tab[pi] = m_tab[pi] - 2'd1;
            end
        end
        if (acc) begin
            m_fifo.push_back({req_idx, pr});
            exp_pred.push_back(pr);
        end
        m_pend = m_fifo.size();
        @(posedge clk);
        #1;
        last_pv = pred_valid;
        last_pt = pred_taken;
        last_mp = mispredict;
        chk("pred_valid", 32'(pred_valid), 32'(exp_pred.size() != 0));
        if (exp_pred.size() != 0) begin
            ept = exp_pred.pop_front();
            chk("pred_taken", 32'(pred_taken), 32'(ept));
        end
        emp = 1'b0;
        if (exp_mp.size() != 0) begin
            emp = exp_mp.pop_front();
        end
        chk("mispredict", 32'(mispredict), 32'(emp));
    endtask

    task automatic req(input logic [3:0] idx);
        req_valid = 1'b1;
        req_idx   = idx;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic res(input logic t);
        res_valid = 1'b1;
        res_taken = t;
        cyc();
        res_valid = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        cyc();

        // Counter training: idx 3 goes 00 -> 01 -> 10, then predicts taken
        req(4'd3);
        chk("r30_first_pred", 32'(last_pt), 32'd0);
        req(4'd3);
        res(1'b1);
        chk("r30_mp_a", 32'(last_mp), 32'd1);
        res(1'b1);
        req(4'd3);
        chk("r30_trained_pred", 32'(last_pt), 32'd1);
        res(1'b1);

        // Full FIFO: fifth request stalls, a same-cycle resolution does not let it through
        req(4'd7);
        req(4'd8);
        req(4'd9);
        req(4'd10);
        chk("r31_pending_full", 32'(pending), 32'd4);
        chk("r31_ready_low", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_idx   = 4'd11;
        cyc();
        chk("r31_held", 32'(last_pv), 32'd0);
        res_valid = 1'b1;
        res_taken = 1'b0;
        cyc();
        chk("r31_no_fallthrough", 32'(last_pv), 32'd0);
        res_valid = 1'b0;
        cyc();
        chk("r31_accepted_after_pop", 32'(last_pv), 32'd1);
        req_valid = 1'b0;
        repeat (4) res(1'b0);

        // Mispredict pulse width and its absence on a correct prediction
        req(4'd5);
        chk("r32_pred_nt", 32'(last_pt), 32'd0);
        res(1'b1);
        chk("r32_mp_pulse", 32'(last_mp), 32'd1);
        cyc();
        chk("r32_mp_one_cycle", 32'(last_mp), 32'd0);
        req(4'd5);
        res(1'b0);
        chk("r32_no_mp", 32'(last_mp), 32'd0);

        // Saturation at strong-taken (idx 3 is 11) and at strong-not-taken (idx 12 is 00)
        req(4'd3);
        req(4'd3);
        req(4'd3);
        repeat (3) res(1'b1);
        req(4'd3);
        chk("r33_sat_hi_a", 32'(last_pt), 32'd1);
        res(1'b0);
        req(4'd3);
        chk("r33_sat_hi_b", 32'(last_pt), 32'd1);
        res(1'b1);
        req(4'd12);
        res(1'b0);
        req(4'd12);
        chk("r33_sat_lo", 32'(last_pt), 32'd0);
        res(1'b1);

        // Resolution with nothing outstanding is ignored
        res(1'b1);
        chk("r21_ignored_mp", 32'(last_mp), 32'd0);
        chk("r21_pending", 32'(pending), 32'd0);

        // Simultaneous push and pop across several pointer wraps
        req(4'd6);
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_idx   = 4'd6;
            res_valid = 1'b1;
            res_taken = i[0];
            cyc();
            chk("r23_pending_steady", 32'(pending), 32'd1);
        end
        req_valid = 1'b0;
        res(1'b0);

        // Flush with 3 pending plus coinciding request and resolution
        req(4'd3);
        res(1'b0);
        req(4'd3);
        req(4'd3);
        req(4'd3);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_idx   = 4'd3;
        res_valid = 1'b1;
        res_taken = 1'b0;
        cyc();
        chk("r34_no_pred", 32'(last_pv), 32'd0);
        chk("r34_no_mp", 32'(last_mp), 32'd0);
        chk("r34_pending_zero", 32'(pending), 32'd0);
        flush     = 1'b0;
        req_valid = 1'b0;
        res_valid = 1'b0;
        req(4'd3);
        chk("r34_counter_kept", 32'(last_pt), 32'd1);
        res(1'b0);

        // Reset lands between an accepted request and its prediction strobe
        req(4'd4);
        req_valid = 1'b1;
        req_idx   = 4'd9;
        res_valid = 1'b1;
        res_taken = 1'b1;
        @(posedge clk);
        req_valid = 1'b0;
        res_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("r35_pred_dropped", 32'(pred_valid), 32'd0);
        chk("r35_mp_dropped", 32'(mispredict), 32'd0);
        chk("r35_pending_cleared", 32'(pending), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            req(4'(i));
            chk("r35_counter_cleared", 32'(last_pt), 32'd0);
            res(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
